// File: rtl/coin_acceptor.sv
// ============================================================================
// coin_acceptor
// ----------------------------------------------------------------------------
// Front-end stage for the vending FSM's 2-bit coin input. It debounces three
// raw coin-sensor lines, rejects hits that involve more than one sensor, and
// flags a jam when a sensor stays active long after its coin was taken. Each
// accepted coin appears as a single-cycle code on 'coin'. The idle code is
// 2'b11. A qualified coin is held back while the vending FSM is dispensing.
//
// Parameters
//   DEB_CYCLES  consecutive stable cycles needed to qualify a press/release
//   JAM_CYCLES  active-sensor cycles after emit before a jam is declared
//   CW          width of the internal cycle counters and of coin_cnt
//
// Ports
//   clk      in   1   system clock, rising edge
//   rst      in   1   synchronous reset, active-low
//   sns      in   3   raw sensors: [0]=unit, [1]=double, [2]=large coin
//   vend     in   1   dispense in progress (coin emission is deferred)
//   coin     out  2   00 unit, 01 double, 10 large, 11 idle
//   reject   out  1   one-cycle pulse on a multi-sensor hit
//   jam      out  1   level, high while a stuck sensor is being reported
//   coin_cnt out  CW  total accepted coins, wraps modulo 2^CW
// ============================================================================
module coin_acceptor #(
    parameter int DEB_CYCLES = 4,
    parameter int JAM_CYCLES = 255,
    parameter int CW         = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    sns,
    input  logic          vend,
    output logic [1:0]    coin,
    output logic          reject,
    output logic          jam,
    output logic [CW-1:0] coin_cnt
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        QUAL    = 3'd1,
        EMIT    = 3'd2,
        RELEASE = 3'd3,
        JAM     = 3'd4
    } state_t;

    localparam logic [CW-1:0] DEB_TERM = CW'(DEB_CYCLES);
    localparam logic [CW-1:0] JAM_TERM = CW'(JAM_CYCLES);
    localparam logic [CW-1:0] ONE      = CW'(1);

    state_t        state, state_d;
    logic [2:0]    cand, cand_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [CW-1:0] relcnt, relcnt_d;
    logic [CW-1:0] jcnt, jcnt_d;

    logic [1:0]    coin_d;
    logic          reject_d;
    logic          jam_d;
    logic [CW-1:0] coin_cnt_d;

    logic          sns_zero;
    logic          sns_onehot;
    logic          bad_hit;
    logic          emit;
    logic [1:0]    cand_code;

    assign sns_zero   = (sns == 3'b000);
    assign sns_onehot = (sns == 3'b001) || (sns == 3'b010) || (sns == 3'b100);

    // Sensor bit to coin code; cand is always one-hot once latched.
    always_comb begin
        case (cand)
            3'b010:  cand_code = 2'b01;
            3'b100:  cand_code = 2'b10;
            default: cand_code = 2'b00;
        endcase
    end

    // State register. Also holds the counters, the candidate sensor and the
    // registered outputs so every output changes only on a clock edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cand     <= 3'b000;
            cnt      <= '0;
            relcnt   <= '0;
            jcnt     <= '0;
            coin     <= 2'b11;
            reject   <= 1'b0;
            jam      <= 1'b0;
            coin_cnt <= '0;
        end else begin
            state    <= state_d;
            cand     <= cand_d;
            cnt      <= cnt_d;
            relcnt   <= relcnt_d;
            jcnt     <= jcnt_d;
            coin     <= coin_d;
            reject   <= reject_d;
            jam      <= jam_d;
            coin_cnt <= coin_cnt_d;
        end
    end

    // Next-state logic. Counters are compared after incrementing, so the
    // transition happens on the edge that brings a counter to its terminal
    // value; a counter therefore never runs past that value within a state.
    // Every path into RELEASE clears both release counters so jam timing is
    // measured from the moment the coin (or rejected hit) was handled.
    always_comb begin
        state_d  = state;
        cand_d   = cand;
        cnt_d    = cnt;
        relcnt_d = relcnt;
        jcnt_d   = jcnt;
        bad_hit  = 1'b0;
        emit     = 1'b0;

        case (state)
            IDLE: begin
                if (sns_onehot) begin
                    cand_d  = sns;
                    cnt_d   = ONE;
                    state_d = (DEB_TERM == ONE) ? EMIT : QUAL;
                end else if (!sns_zero) begin
                    bad_hit  = 1'b1;
                    relcnt_d = '0;
                    jcnt_d   = '0;
                    state_d  = RELEASE;
                end
            end

            QUAL: begin
                if (sns == cand) begin
                    cnt_d = cnt + ONE;
                    if (cnt + ONE == DEB_TERM) begin
                        state_d = EMIT;
                    end
                end else if (sns_zero) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    bad_hit  = 1'b1;
                    relcnt_d = '0;
                    jcnt_d   = '0;
                    state_d  = RELEASE;
                end
            end

            EMIT: begin
                if (!vend) begin
                    emit     = 1'b1;
                    relcnt_d = '0;
                    jcnt_d   = '0;
                    state_d  = RELEASE;
                end
            end

            // Re-arm only after a debounced release; a sensor that keeps
            // reporting long after its coin was taken is treated as stuck.
            RELEASE: begin
                if (sns_zero) begin
                    relcnt_d = relcnt + ONE;
                    if (relcnt + ONE == DEB_TERM) begin
                        cnt_d    = '0;
                        relcnt_d = '0;
                        jcnt_d   = '0;
                        state_d  = IDLE;
                    end
                end else begin
                    relcnt_d = '0;
                    jcnt_d   = jcnt + ONE;
                    if (jcnt + ONE == JAM_TERM) begin
                        state_d = JAM;
                    end
                end
            end

            JAM: begin
                if (sns_zero) begin
                    relcnt_d = relcnt + ONE;
                    if (relcnt + ONE == DEB_TERM) begin
                        cnt_d    = '0;
                        relcnt_d = '0;
                        jcnt_d   = '0;
                        state_d  = IDLE;
                    end
                end else begin
                    relcnt_d = '0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic. emit and bad_hit come from mutually exclusive branches,
    // so a coin code and a reject pulse can never be registered together.
    always_comb begin
        coin_d     = emit ? cand_code : 2'b11;
        reject_d   = bad_hit;
        jam_d      = (state_d == JAM);
        coin_cnt_d = coin_cnt + CW'(emit);
    end

endmodule

// File: tb/tb_coin_acceptor.sv
// ============================================================================
// tb_coin_acceptor
// ----------------------------------------------------------------------------
// Directed, self-checking bench for coin_acceptor with DEB_CYCLES=4,
// JAM_CYCLES=255, CW=8. Inputs change 1 ns after a rising edge, and outputs
// are sampled at the same point, so they reflect the edge just taken.
// ============================================================================
module tb_coin_acceptor;

    logic       clk;
    logic       rst;
    logic [2:0] sns;
    logic       vend;
    logic [1:0] coin;
    logic       reject;
    logic       jam;
    logic [7:0] coin_cnt;

    int vectors;
    int miscompares;

    coin_acceptor #(
        .DEB_CYCLES(4),
        .JAM_CYCLES(255),
        .CW(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sns(sns),
        .vend(vend),
        .coin(coin),
        .reject(reject),
        .jam(jam),
        .coin_cnt(coin_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one clean coin: held for 5 edges (emit on edge 5),
    // then released long enough to re-arm.
    task automatic insert_coin(input logic [2:0] s);
        sns = s;
        repeat (5) tick();
        sns = 3'b000;
        repeat (5) tick();
    endtask

    task automatic test_reset();
        rst  = 1'b0;
        sns  = 3'b000;
        vend = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        vectors++; if (coin !== 2'b11) begin miscompares++; $display("[TB] FAIL reset_coin got=%b exp=11", coin); end
        vectors++; if (reject !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_reject got=%b exp=0", reject); end
        vectors++; if (jam !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_jam got=%b exp=0", jam); end
        vectors++; if (coin_cnt !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_cnt got=%0d exp=0", coin_cnt); end
    endtask

    task automatic test_single_coin();
        sns = 3'b001;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 5) begin
                vectors++; if (coin !== 2'b00) begin miscompares++; $display("[TB] FAIL t1_emit got=%b exp=00", coin); end
                vectors++; if (coin_cnt !== 8'd1) begin miscompares++; $display("[TB] FAIL t1_cnt got=%0d exp=1", coin_cnt); end
            end else begin
                vectors++; if (coin !== 2'b11) begin miscompares++; $display("[TB] FAIL t1_idle cyc=%0d got=%b exp=11", i, coin); end
            end
            vectors++; if (reject !== 1'b0) begin miscompares++; $display("[TB] FAIL t1_reject cyc=%0d got=%b exp=0", i, reject); end
        end
        sns = 3'b000;
        repeat (5) tick();
        vectors++; if (coin_cnt !== 8'd1) begin miscompares++; $display("[TB] FAIL t1_cnt_after got=%0d exp=1", coin_cnt); end
    endtask

    task automatic test_glitch();
        sns = 3'b010;
        repeat (2) tick();
        sns = 3'b000;
        for (int i = 0; i < 8; i++) begin
            tick();
            vectors++; if (coin !== 2'b11) begin miscompares++; $display("[TB] FAIL t2_glitch cyc=%0d got=%b exp=11", i, coin); end
        end
        vectors++; if (coin_cnt !== 8'd1) begin miscompares++; $display("[TB] FAIL t2_cnt got=%0d exp=1", coin_cnt); end
        // Back in IDLE: a real double coin now qualifies with normal latency.
        sns = 3'b010;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i == 5) begin
                vectors++; if (coin !== 2'b01) begin miscompares++; $display("[TB] FAIL t2_emit got=%b exp=01", coin); end
            end else begin
                vectors++; if (coin !== 2'b11) begin miscompares++; $display("[TB] FAIL t2_idle cyc=%0d got=%b exp=11", i, coin); end
            end
        end
        vectors++; if (coin_cnt !== 8'd2) begin miscompares++; $display("[TB] FAIL t2_cnt_after got=%0d exp=2", coin_cnt); end
        sns = 3'b000;
        repeat (5) tick();
    endtask

    task automatic test_multi_hit();
        int rej_count;
        rej_count = 0;
        sns = 3'b101;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 4) sns = 3'b000;
            if (reject === 1'b1) rej_count++;
            if (i == 1) begin
                vectors++; if (reject !== 1'b1) begin miscompares++; $display("[TB] FAIL t3_reject got=%b exp=1", reject); end
            end
            vectors++; if (coin !== 2'b11) begin miscompares++; $display("[TB] FAIL t3_coin cyc=%0d got=%b exp=11", i, coin); end
        end
        vectors++; if (rej_count !== 1) begin miscompares++; $display("[TB] FAIL t3_pulse_len got=%0d exp=1", rej_count); end
        vectors++; if (coin_cnt !== 8'd2) begin miscompares++; $display("[TB] FAIL t3_cnt got=%0d exp=2", coin_cnt); end
        // A different sensor appearing mid-qualification is also rejected.
        sns = 3'b001;
        repeat (2) tick();
        sns = 3'b010;
        tick();
        vectors++; if (reject !== 1'b1) begin miscompares++; $display("[TB] FAIL t3_qual_reject got=%b exp=1", reject); end
        sns = 3'b000;
        tick();
        vectors++; if (reject !== 1'b0) begin miscompares++; $display("[TB] FAIL t3_qual_reject_end got=%b exp=0", reject); end
        repeat (8) tick();
        vectors++; if (coin_cnt !== 8'd2) begin miscompares++; $display("[TB] FAIL t3_qual_cnt got=%0d exp=2", coin_cnt); end
    endtask

    task automatic test_vend_hold();
        vend = 1'b1;
        sns  = 3'b100;
        for (int i = 1; i <= 7; i++) begin
            tick();
            vectors++; if (coin !== 2'b11) begin miscompares++; $display("[TB] FAIL t4_held cyc=%0d got=%b exp=11", i, coin); end
        end
        vend = 1'b0;
        tick();
        vectors++; if (coin !== 2'b10) begin miscompares++; $display("[TB] FAIL t4_emit got=%b exp=10", coin); end
        vectors++; if (coin_cnt !== 8'd3) begin miscompares++; $display("[TB] FAIL t4_cnt got=%0d exp=3", coin_cnt); end
        tick();
        vectors++; if (coin !== 2'b11) begin miscompares++; $display("[TB] FAIL t4_after got=%b exp=11", coin); end
        sns = 3'b000;
        repeat (5) tick();
    endtask

    task automatic test_jam();
        int emits;
        emits = 0;
        sns = 3'b001;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (coin !== 2'b11) emits++;
            if (i == 5) begin
                vectors++; if (coin !== 2'b00) begin miscompares++; $display("[TB] FAIL t5_emit got=%b exp=00", coin); end
            end
            if (i == 259) begin
                vectors++; if (jam !== 1'b0) begin miscompares++; $display("[TB] FAIL t5_jam_early got=%b exp=0", jam); end
            end
            if (i == 260 || i == 300) begin
                vectors++; if (jam !== 1'b1) begin miscompares++; $display("[TB] FAIL t5_jam cyc=%0d got=%b exp=1", i, jam); end
            end
        end
        sns = 3'b000;
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (coin !== 2'b11) emits++;
            if (i == 3) begin
                vectors++; if (jam !== 1'b1) begin miscompares++; $display("[TB] FAIL t5_jam_hold got=%b exp=1", jam); end
            end
        end
        vectors++; if (jam !== 1'b0) begin miscompares++; $display("[TB] FAIL t5_jam_clear got=%b exp=0", jam); end
        vectors++; if (emits !== 1) begin miscompares++; $display("[TB] FAIL t5_emit_count got=%0d exp=1", emits); end
        vectors++; if (coin_cnt !== 8'd4) begin miscompares++; $display("[TB] FAIL t5_cnt got=%0d exp=4", coin_cnt); end
        tick();
    endtask

    task automatic test_reset_in_qual();
        sns = 3'b001;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        vectors++; if (coin_cnt !== 8'd0) begin miscompares++; $display("[TB] FAIL t6_rst_cnt got=%0d exp=0", coin_cnt); end
        sns = 3'b000;
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            vectors++; if (coin !== 2'b11) begin miscompares++; $display("[TB] FAIL t6_no_emit cyc=%0d got=%b exp=11", i, coin); end
        end
        vectors++; if (coin_cnt !== 8'd0) begin miscompares++; $display("[TB] FAIL t6_cnt_hold got=%0d exp=0", coin_cnt); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 255; i++) begin
            insert_coin((i % 3 == 0) ? 3'b001 : ((i % 3 == 1) ? 3'b010 : 3'b100));
        end
        vectors++; if (coin_cnt !== 8'd255) begin miscompares++; $display("[TB] FAIL wrap_255 got=%0d exp=255", coin_cnt); end
        insert_coin(3'b010);
        vectors++; if (coin_cnt !== 8'd0) begin miscompares++; $display("[TB] FAIL wrap_0 got=%0d exp=0", coin_cnt); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst  = 1'b0;
        sns  = 3'b000;
        vend = 1'b0;
        test_reset();
        test_single_coin();
        test_glitch();
        test_multi_hit();
        test_vend_hold();
        test_jam();
        test_reset_in_qual();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
